instr_decode_stage: RTL and testbench
=====================================

Name: instr_decode_stage

Overview:
Instruction-decode pipeline stage of the 16-bit processor, sitting between fetch and execute. It holds the 8-entry general-purpose register file, which the writeback stage writes. It decodes the fetched instruction into register operands, immediate, jump address and execute/memory/writeback control signals. All decode results are captured in the ID/EX pipeline register.

Parameters:
ARQ, 16, datapath/instruction width; register width and operand output width.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous active-high reset
instr  input  ARQ  instruction being decoded
wb_result  input  ARQ  writeback data for the register file
wr_register  input  1  register-file write enable (from writeback)
out1  output  ARQ  operand A = reg[instr[12:10]]
out2  output  ARQ  operand B = reg[instr[9:7]]
out3  output  ARQ  operand C = reg[instr[6:4]]
imm  output  10  immediate = instr[9:0]
addr  output  14  jump target = {1'b0, instr[12:0]}
jop_lsb  output  1  jump kind: 1 = conditional (JEQ), 0 = unconditional (J)
rd_mem_en  output  1  data-memory read enable
wr_mem_en  output  1  data-memory write enable
mux_exe  output  1  ALU operand-B select: 1 = imm, 0 = register
mux_mem  output  1  writeback select: 1 = memory data, 0 = ALU result
jenable  output  1  instruction is a jump
wb_enable  output  1  instruction writes a register
alu_op  output  2  00 ADD, 01 CMPEQ, 10 MODEX, 11 PASS-imm

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Encoding: opcode = instr[15:13]; rd/ra = [12:10]; rb = [9:7]; rc = [6:4]; imm10 = [9:0]; jump addr = [12:0].
- Opcodes and control (unlisted control signals = 0):
  - 000 SET: alu_op 11, mux_exe 1, wb_enable 1.
  - 001 LDPX: rd_mem_en 1, mux_mem 1, wb_enable 1.
  - 010 MODEX: alu_op 10, wb_enable 1.
  - 011 STPX: wr_mem_en 1.
  - 100 CMPEQ: alu_op 01.
  - 101 JEQ: jenable 1, jop_lsb 1.
  - 110 J: jenable 1, jop_lsb 0.
  - 111 ADD imm: alu_op 00, mux_exe 1, wb_enable 1.
- Register file: 8 x ARQ bits.
  - Write on rising clk when wr_register=1: reg[instr[12:10]] <= wb_result.
  - Three combinational read ports; no internal bypass.
  - On a same-edge read/write of the same register, the outputs capture the OLD value; the new value is visible one cycle later.
- All outputs (out1-3, imm, addr, every control signal, alu_op) are registered: each updates at the rising edge after instr is applied, so latency is 1 cycle.
- Reset: asynchronous; clears all 8 registers and every output to 0 immediately, independent of clk. Writes are ignored while rst=1. Reset mid-operation discards the in-flight decode.
- imm and addr are always driven from instr bits regardless of opcode; consumers qualify them with the control signals.
- X/Z on instr is not handled specially.

Test Plan:
- Reset: rst=1 mid-cycle -> all outputs 0 immediately; after release, reading any register returns 0.
- Writes: SET R1 (0x0411) with wr_register=1, wb_result=451, then SET R0 (0x0013) with wb_result=555 -> a later MODEX with ra=R0, rb=R1 gives out1=555, out2=451.
- Read-during-write: instr 0x0411, wr_register=1, wb_result=451 with R1 previously 0 -> out1 shows 0 on that edge and 451 on the next decode.
- Control decode: one vector per opcode.
  - 0x2500 LDPX -> rd_mem_en=1, mux_mem=1, wb_enable=1.
  - 0x7380 STPX -> wr_mem_en=1, wb_enable=0.
  - 0x40A0 MODEX -> alu_op=10, out3=reg[2].
  - 0x8010 CMPEQ -> alu_op=01, wb_enable=0.
- Jumps: 0xA004 JEQ -> jenable=1, jop_lsb=1, addr=4; 0xC005 J -> jenable=1, jop_lsb=0, addr=5.
- Immediate: 0xEC0F ADD R3,15 -> alu_op=00, mux_exe=1, imm=15, wb_enable=1; with wr_register=1 and wb_result=100, R3 reads 100 on the next decode.

Source files
------------

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - decode stage: register file, instruction decode and ID/EX pipeline register
// Operand reads are combinational from the register file and captured together with decode results.
module instr_decode_stage #(
    parameter int ARQ = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [ARQ-1:0] instr,
    input  logic [ARQ-1:0] wb_result,
    input  logic           wr_register,
    output logic [ARQ-1:0] out1,
    output logic [ARQ-1:0] out2,
    output logic [ARQ-1:0] out3,
    output logic [9:0]     imm,
    output logic [13:0]    addr,
    output logic           jop_lsb,
    output logic           rd_mem_en,
    output logic           wr_mem_en,
    output logic           mux_exe,
    output logic           mux_mem,
    output logic           jenable,
    output logic           wb_enable,
    output logic [1:0]     alu_op
);

    typedef enum logic [2:0] {
        OP_SET   = 3'b000,
        OP_LDPX  = 3'b001,
        OP_MODEX = 3'b010,
        OP_STPX  = 3'b011,
        OP_CMPEQ = 3'b100,
        OP_JEQ   = 3'b101,
        OP_J     = 3'b110,
        OP_ADDI  = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_CMPEQ = 2'b01,
        ALU_MODEX = 2'b10,
        ALU_PASS  = 2'b11
    } alu_op_t;

    typedef struct packed {
        logic    rd_mem_en;
        logic    wr_mem_en;
        logic    mux_exe;
        logic    mux_mem;
        logic    jenable;
        logic    wb_enable;
        logic    jop_lsb;
        alu_op_t alu_op;
    } ctrl_t;

    opcode_t        opcode;
    logic [2:0]     ra_sel;
    logic [2:0]     rb_sel;
    logic [2:0]     rc_sel;
    ctrl_t          ctrl_next;
    ctrl_t          ctrl_q;
    logic [ARQ-1:0] regs [8];

    assign opcode = opcode_t'(instr[15:13]);
    assign ra_sel = instr[12:10];
    assign rb_sel = instr[9:7];
    assign rc_sel = instr[6:4];

    always_comb begin
        ctrl_next = '0;
        unique case (opcode)
            OP_SET: begin
                ctrl_next.alu_op    = ALU_PASS;
                ctrl_next.mux_exe   = 1'b1;
                ctrl_next.wb_enable = 1'b1;
            end
            OP_LDPX: begin
                ctrl_next.rd_mem_en = 1'b1;
                ctrl_next.mux_mem   = 1'b1;
                ctrl_next.wb_enable = 1'b1;
            end
            OP_MODEX: begin
                ctrl_next.alu_op    = ALU_MODEX;
                ctrl_next.wb_enable = 1'b1;
            end
            OP_STPX: begin
                ctrl_next.wr_mem_en = 1'b1;
            end
            OP_CMPEQ: begin
                ctrl_next.alu_op = ALU_CMPEQ;
            end
            OP_JEQ: begin
                ctrl_next.jenable = 1'b1;
                ctrl_next.jop_lsb = 1'b1;
            end
            OP_J: begin
                ctrl_next.jenable = 1'b1;
            end
            OP_ADDI: begin
                ctrl_next.alu_op    = ALU_ADD;
                ctrl_next.mux_exe   = 1'b1;
                ctrl_next.wb_enable = 1'b1;
            end
            default: ctrl_next = '0;
        endcase
    end

    // Writeback targets the register named by the instruction currently in decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_register) begin
            regs[ra_sel] <= wb_result;
        end
    end

    // Reads sample the pre-edge register contents, so a same-edge write shows up one decode later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out1   <= '0;
            out2   <= '0;
            out3   <= '0;
            imm    <= '0;
            addr   <= '0;
            ctrl_q <= '0;
        end else begin
            out1   <= regs[ra_sel];
            out2   <= regs[rb_sel];
            out3   <= regs[rc_sel];
            imm    <= instr[9:0];
            addr   <= {1'b0, instr[12:0]};
            ctrl_q <= ctrl_next;
        end
    end

    assign rd_mem_en = ctrl_q.rd_mem_en;
    assign wr_mem_en = ctrl_q.wr_mem_en;
    assign mux_exe   = ctrl_q.mux_exe;
    assign mux_mem   = ctrl_q.mux_mem;
    assign jenable   = ctrl_q.jenable;
    assign wb_enable = ctrl_q.wb_enable;
    assign jop_lsb   = ctrl_q.jop_lsb;
    assign alu_op    = ctrl_q.alu_op;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - directed and randomized bench for instr_decode_stage against a behavioural model
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic [15:0] wb_result;
    logic        wr_register;
    logic [15:0] out1, out2, out3;
    logic [9:0]  imm;
    logic [13:0] addr;
    logic        jop_lsb, rd_mem_en, wr_mem_en, mux_exe, mux_mem, jenable, wb_enable;
    logic [1:0]  alu_op;

    int checks = 0;
    int failures = 0;

    logic [15:0] mreg [8];

    // Control per opcode, packed {rd_mem, wr_mem, mux_exe, mux_mem, jenable, wb_enable, jop_lsb, alu_op[1:0]}.
    logic [8:0] ctrl_table [8] = '{
        9'b0_0_1_0_0_1_0_11,
        9'b1_0_0_1_0_1_0_00,
        9'b0_0_0_0_0_1_0_10,
        9'b0_1_0_0_0_0_0_00,
        9'b0_0_0_0_0_0_0_01,
        9'b0_0_0_0_1_0_1_00,
        9'b0_0_0_0_1_0_0_00,
        9'b0_0_1_0_0_1_0_00
    };

    instr_decode_stage #(.ARQ(16)) dut (
        .clk(clk), .rst(rst), .instr(instr), .wb_result(wb_result), .wr_register(wr_register),
        .out1(out1), .out2(out2), .out3(out3), .imm(imm), .addr(addr), .jop_lsb(jop_lsb),
        .rd_mem_en(rd_mem_en), .wr_mem_en(wr_mem_en), .mux_exe(mux_exe), .mux_mem(mux_mem),
        .jenable(jenable), .wb_enable(wb_enable), .alu_op(alu_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [8:0] ctrl_obs();
        return {rd_mem_en, wr_mem_en, mux_exe, mux_mem, jenable, wb_enable, jop_lsb, alu_op};
    endfunction

    task automatic apply(input logic [15:0] i, input logic [15:0] wb, input logic wr);
        logic [15:0] e1, e2, e3;
        logic [8:0]  ec;
        @(negedge clk);
        instr = i;
        wb_result = wb;
        wr_register = wr;
        e1 = mreg[i[12:10]];
        e2 = mreg[i[9:7]];
        e3 = mreg[i[6:4]];
        ec = ctrl_table[i[15:13]];
        @(posedge clk);
        if (wr) mreg[i[12:10]] = wb;
        #1;
        check("out1", out1, e1);
        check("out2", out2, e2);
        check("out3", out3, e3);
        check("imm", imm, i % 1024);
        check("addr", addr, i % 8192);
        check("ctrl", ctrl_obs(), ec);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        wr_register = 1'b1;
        wb_result = 16'hBEEF;
        #1;
        check("rst_out1", out1, 0);
        check("rst_out2", out2, 0);
        check("rst_out3", out3, 0);
        check("rst_imm_addr", {imm, addr}, 0);
        check("rst_ctrl", ctrl_obs(), 0);
        for (int k = 0; k < 8; k++) mreg[k] = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wr_register = 1'b0;
    endtask

    task automatic read_all_regs();
        apply({3'b010, 3'd0, 3'd1, 3'd2, 4'd0}, 16'd0, 1'b0);
        apply({3'b010, 3'd3, 3'd4, 3'd5, 4'd0}, 16'd0, 1'b0);
        apply({3'b010, 3'd6, 3'd7, 3'd0, 4'd0}, 16'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        instr = '0;
        wb_result = '0;
        wr_register = 1'b0;
        for (int k = 0; k < 8; k++) mreg[k] = '0;
        #1;
        check("init_out1", out1, 0);
        check("init_ctrl", ctrl_obs(), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        read_all_regs();

        apply(16'h0411, 16'd451, 1'b1);
        check("rdw_old_r1", out1, 0);
        apply(16'h0013, 16'd555, 1'b1);
        apply(16'h0411, 16'd0, 1'b0);
        check("rdw_new_r1", out1, 451);
        apply(16'h4080, 16'd0, 1'b0);
        check("modex_a", out1, 555);
        check("modex_b", out2, 451);

        apply(16'h2500, 16'd0, 1'b0);
        apply(16'h7380, 16'd0, 1'b0);
        apply(16'h40A0, 16'd0, 1'b0);
        apply(16'h8010, 16'd0, 1'b0);
        apply(16'hA004, 16'd0, 1'b0);
        check("jeq_addr", addr, 4);
        apply(16'hC005, 16'd0, 1'b0);
        check("j_addr", addr, 5);
        apply(16'hEC0F, 16'd100, 1'b1);
        check("addi_imm", imm, 15);
        apply(16'hEC0F, 16'd0, 1'b0);
        check("addi_r3", out1, 100);

        mid_reset();
        read_all_regs();

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                mid_reset();
            end else begin
                apply(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            end
        end
        read_all_regs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
